// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch-unit bus: I-cache port, redirects, decode queue head
interface if_fetch_queue_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] ic_pc;
   logic              ic_req;
   logic              ic_hit;
   logic [31:0]       ic_inst;
   logic              br_valid;
   logic [ADDR_W-1:0] br_target;
   logic              jmp_valid;
   logic [ADDR_W-1:0] jmp_target;
   logic              dec_valid;
   logic              dec_ready;
   logic [ADDR_W-1:0] dec_pc;
   logic [31:0]       dec_inst;
   logic [31:0]       inst_count;

   // fetch unit side
   modport master (
      output ic_pc, ic_req, dec_valid, dec_pc, dec_inst, inst_count,
      input  ic_hit, ic_inst, br_valid, br_target, jmp_valid, jmp_target, dec_ready
   );

   // I-cache / execute / decoder side
   modport slave (
      input  ic_pc, ic_req, dec_valid, dec_pc, dec_inst, inst_count,
      output ic_hit, ic_inst, br_valid, br_target, jmp_valid, jmp_target, dec_ready
   );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch with decoupling queue; IF_BRANCH_PREDICT_EN selects static BTFN branch prediction
module if_fetch_queue #(
   parameter int              ADDR_W   = 32,
   parameter int              QDEPTH   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   if_fetch_queue_if.master bus
);
   localparam int IDX_W = $clog2(QDEPTH);
   localparam int PTR_W = IDX_W + 1;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

`ifdef IF_BRANCH_PREDICT_EN
   typedef enum logic [1:0] {RUN = 2'd0, WAIT_JALR = 2'd1} state_t;
`else
   typedef enum logic [1:0] {RUN = 2'd0, WAIT_JALR = 2'd1, WAIT_BR = 2'd2} state_t;
`endif

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [31:0]        count_q, count_d;
   logic               push;
   logic               full;
   logic               empty;
   logic               jmp_take;

   logic [ADDR_W-1:0]  pc_mem   [QDEPTH];
   logic [31:0]        inst_mem [QDEPTH];

   logic [6:0]         opcode;
   logic signed [20:0] jal_off;
`ifdef IF_BRANCH_PREDICT_EN
   logic signed [12:0] br_off;
   assign br_off = {bus.ic_inst[31], bus.ic_inst[7], bus.ic_inst[30:25], bus.ic_inst[11:8], 1'b0};
`endif

   assign opcode  = bus.ic_inst[6:0];
   assign jal_off = {bus.ic_inst[31], bus.ic_inst[19:12], bus.ic_inst[20], bus.ic_inst[30:21], 1'b0};

   assign full  = (tail_q[IDX_W-1:0] == head_q[IDX_W-1:0]) && (tail_q[IDX_W] != head_q[IDX_W]);
   assign empty = (tail_q == head_q);

   // a pending branch cannot be resolved by a JALR target, so jmp_valid only acts outside WAIT_BR
`ifdef IF_BRANCH_PREDICT_EN
   assign jmp_take = bus.jmp_valid;
`else
   assign jmp_take = bus.jmp_valid && (state_q != WAIT_BR);
`endif

   assign bus.ic_pc      = fetch_pc_q;
   assign bus.ic_req     = rdy & ~rst & (state_q == RUN) & ~full;
   assign bus.dec_valid  = rdy & ~rst & ~empty;
   assign bus.dec_pc     = pc_mem[head_q[IDX_W-1:0]];
   assign bus.dec_inst   = inst_mem[head_q[IDX_W-1:0]];
   assign bus.inst_count = count_q;

   // next-state: redirects first, otherwise pop/push and next fetch PC from the fetched opcode
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      push       = 1'b0;
      if (rdy) begin
         if (bus.br_valid) begin
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = bus.br_target;
            state_d    = RUN;
         end else if (jmp_take) begin
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = bus.jmp_target;
            state_d    = RUN;
         end else begin
            if (bus.dec_valid && bus.dec_ready) begin
               head_d = head_q + PTR_W'(1);
            end
            if ((state_q == RUN) && !full && bus.ic_hit) begin
               push       = 1'b1;
               tail_d     = tail_q + PTR_W'(1);
               count_d    = count_q + 32'd1;
               fetch_pc_d = fetch_pc_q + ADDR_W'(4);
               case (opcode)
                  OP_JAL: fetch_pc_d = fetch_pc_q + ADDR_W'(jal_off);
                  OP_JALR: begin
                     if (bus.ic_inst[14:12] == 3'b000) begin
                        state_d = WAIT_JALR;
                     end
                  end
                  OP_BRANCH: begin
`ifdef IF_BRANCH_PREDICT_EN
                     if (bus.ic_inst[31]) begin
                        fetch_pc_d = fetch_pc_q + ADDR_W'(br_off);
                     end
`else
                     state_d = WAIT_BR;
`endif
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // state, PC, pointer and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // queue storage: write the fetched PC and word at the tail
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         pc_mem[tail_q[IDX_W-1:0]]   <= fetch_pc_q;
         inst_mem[tail_q[IDX_W-1:0]] <= bus.ic_inst;
      end
   end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed vector bench for if_fetch_queue
module tb_if_fetch_queue;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] JAL  = 32'h1000_006F;
   localparam logic [31:0] JALR = 32'h0000_8067;
   localparam logic [31:0] BR   = 32'hFE00_0863;
`ifdef IF_BRANCH_PREDICT_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   typedef struct {
      logic        rdy;
      logic        hit;
      logic [31:0] inst;
      logic        brv;
      logic [31:0] brt;
      logic        jv;
      logic [31:0] jt;
      logic        drdy;
      logic [31:0] e_pc;
      logic        e_req;
      logic        e_dv;
      logic [31:0] e_dpc;
      logic [31:0] e_dinst;
      logic [31:0] e_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t tbl[$];

   if_fetch_queue_if #(.ADDR_W(32)) bus ();

   if_fetch_queue #(.ADDR_W(32), .QDEPTH(4), .RESET_PC(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic h, logic [31:0] i, logic bv, logic [31:0] bt,
                               logic jv, logic [31:0] jt, logic dr, logic [31:0] pc, logic rq,
                               logic dv, logic [31:0] dpc, logic [31:0] di, logic [31:0] cnt);
      vec_t v;
      v.rdy = r; v.hit = h; v.inst = i; v.brv = bv; v.brt = bt; v.jv = jv; v.jt = jt; v.drdy = dr;
      v.e_pc = pc; v.e_req = rq; v.e_dv = dv; v.e_dpc = dpc; v.e_dinst = di; v.e_cnt = cnt;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(logic r, logic h, logic [31:0] i, logic bv, logic [31:0] bt,
                        logic jv, logic [31:0] jt, logic dr);
      rdy = r; bus.ic_hit = h; bus.ic_inst = i; bus.br_valid = bv; bus.br_target = bt;
      bus.jmp_valid = jv; bus.jmp_target = jt; bus.dec_ready = dr;
   endtask

   initial begin
      // fill from reset: queue fills, then drains in order while streaming
      tbl.push_back(mk(1,1,NOP,0,0,0,0,0, 32'h00,1,0,0,0,0));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,0, 32'h04,1,1,32'h00,NOP,1));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,0, 32'h08,1,1,32'h00,NOP,2));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,0, 32'h0C,1,1,32'h00,NOP,3));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,0, 32'h10,0,1,32'h00,NOP,4));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,0, 32'h10,0,1,32'h00,NOP,4));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,1, 32'h10,0,1,32'h00,NOP,4));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,1, 32'h10,1,1,32'h04,NOP,4));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,1, 32'h14,1,1,32'h08,NOP,5));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,1, 32'h18,1,1,32'h0C,NOP,6));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,1, 32'h1C,1,1,32'h10,NOP,7));
      // rdy low freezes everything
      tbl.push_back(mk(0,1,NOP,0,0,0,0,1, 32'h20,0,0,0,0,8));
      tbl.push_back(mk(0,1,NOP,1,32'h500,0,0,1, 32'h20,0,0,0,0,8));
      tbl.push_back(mk(0,1,NOP,0,0,0,0,1, 32'h20,0,0,0,0,8));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,1, 32'h20,1,1,32'h14,NOP,8));
      // redirect to 0x8, JAL +0x100, JALR waits for target 0x40
      tbl.push_back(mk(1,1,NOP,1,32'h08,0,0,1, 32'h24,1,1,32'h18,NOP,9));
      tbl.push_back(mk(1,1,JAL,0,0,0,0,1, 32'h08,1,0,0,0,9));
      tbl.push_back(mk(1,1,JALR,0,0,0,0,1, 32'h108,1,1,32'h08,JAL,10));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,1, 32'h10C,0,1,32'h108,JALR,11));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,1, 32'h10C,0,0,0,0,11));
      tbl.push_back(mk(1,1,NOP,0,0,1,32'h40,1, 32'h10C,0,0,0,0,11));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,1, 32'h40,1,0,0,0,11));
      // redirect to 0x20, backward branch -0x10, resolved to 0x24
      tbl.push_back(mk(1,1,NOP,1,32'h20,0,0,1, 32'h44,1,1,32'h40,NOP,12));
      tbl.push_back(mk(1,1,BR,0,0,0,0,1, 32'h20,1,0,0,0,12));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,1, BP ? 32'h10 : 32'h24, BP,1,32'h20,BR,13));
      tbl.push_back(mk(1,1,NOP,1,32'h24,0,0,1, BP ? 32'h14 : 32'h24, BP,BP,32'h10,NOP, BP ? 32'd14 : 32'd13));
      tbl.push_back(mk(1,1,NOP,0,0,0,0,1, 32'h24,1,0,0,0, 32'd13 + 32'(BP)));
      // simultaneous redirects: branch wins
      tbl.push_back(mk(1,1,NOP,1,32'h200,1,32'h300,1, 32'h28,1,1,32'h24,NOP, 32'd14 + 32'(BP)));
      tbl.push_back(mk(1,0,NOP,0,0,0,0,1, 32'h200,1,0,0,0, 32'd14 + 32'(BP)));

      rst = 1'b1;
      drive(1,0,NOP,0,0,0,0,0);
      repeat (2) @(negedge clk);
      #1;
      chk("reset ic_req", 32'(bus.ic_req), 32'd0);
      chk("reset dec_valid", 32'(bus.dec_valid), 32'd0);
      rst = 1'b0;

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clk);
         drive(tbl[k].rdy, tbl[k].hit, tbl[k].inst, tbl[k].brv, tbl[k].brt,
               tbl[k].jv, tbl[k].jt, tbl[k].drdy);
         #1;
         chk($sformatf("row%0d ic_pc", k), bus.ic_pc, tbl[k].e_pc);
         chk($sformatf("row%0d ic_req", k), 32'(bus.ic_req), 32'(tbl[k].e_req));
         chk($sformatf("row%0d dec_valid", k), 32'(bus.dec_valid), 32'(tbl[k].e_dv));
         chk($sformatf("row%0d inst_count", k), bus.inst_count, tbl[k].e_cnt);
         if (tbl[k].e_dv) begin
            chk($sformatf("row%0d dec_pc", k), bus.dec_pc, tbl[k].e_dpc);
            chk($sformatf("row%0d dec_inst", k), bus.dec_inst, tbl[k].e_dinst);
         end
      end

      // fill the queue from 0x200, then reset with it full
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive(1,1,NOP,0,0,0,0,0);
      end
      @(negedge clk);
      #1;
      chk("full ic_req", 32'(bus.ic_req), 32'd0);
      chk("full ic_pc", bus.ic_pc, 32'h210);
      chk("full dec_pc", bus.dec_pc, 32'h200);
      rst = 1'b1;
      drive(1,1,NOP,1,32'h400,0,0,1);
      #1;
      chk("in-reset ic_req", 32'(bus.ic_req), 32'd0);
      chk("in-reset dec_valid", 32'(bus.dec_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(1,0,NOP,0,0,0,0,1);
      #1;
      chk("post-reset dec_valid", 32'(bus.dec_valid), 32'd0);
      chk("post-reset ic_pc", bus.ic_pc, 32'h0);
      chk("post-reset inst_count", bus.inst_count, 32'd0);
      chk("post-reset ic_req", 32'(bus.ic_req), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
